// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared state encoding and default sizes for the memory interface
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: wait-cycle counter that flags the last allowed cycle before timeout
module mem_timeout_ctr
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR register pair with a request/ack handshake and timeout
module mem_interface
  import mem_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              e_MAR,
  input  logic              e_MDR,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] MDR_out,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic err_q, err_d;
  logic expired;
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .reset(reset),
    .clr(!busy),
    .en(busy),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        mar_d = e_MAR ? bus_in[ADDR_W-1:0] : mar_q;
        mdr_d = e_MDR ? bus_in : mdr_q;
        state_d = mem_read ? READ : mem_write ? WRITE : IDLE;
      end
      READ, WRITE: begin
        mdr_d = (mem_ack && state_q == READ) ? mem_rdata : mdr_q;
        state_d = (mem_ack || expired) ? DONE : state_q;
        err_d = expired && !mem_ack;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      mar_q <= '0;
      mdr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      err_q <= err_d;
    end
  assign busy = state_q == READ || state_q == WRITE;
  assign mem_req = busy;
  assign mem_we = state_q == WRITE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign mem_addr = mar_q;
  assign mem_wdata = mdr_q;
  assign MDR_out = mdr_q;
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed checks of load, read, write, timeout and reset behaviour
module tb_mem_interface;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] bus_in = '0;
  logic e_MAR = 1'b0;
  logic e_MDR = 1'b0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic [8:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_req;
  logic mem_we;
  logic [31:0] MDR_out;
  logic busy;
  logic done;
  logic err;
  int n_chk = 0;
  int n_fail = 0;
  int bc;
  int dc;
  mem_interface dut (
    .clk(clk),
    .reset(reset),
    .bus_in(bus_in),
    .e_MAR(e_MAR),
    .e_MDR(e_MDR),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .MDR_out(MDR_out),
    .busy(busy),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mdr"}, MDR_out, 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask
  initial begin
    cyc();
    cyc();
    chk_idle_zero("rst");
    reset = 1'b1;
    bus_in = 32'h0000_0005;
    e_MAR = 1'b1;
    cyc();
    e_MAR = 1'b0;
    bus_in = 32'hDEAD_BEEF;
    e_MDR = 1'b1;
    cyc();
    e_MDR = 1'b0;
    mem_write = 1'b1;
    cyc();
    mem_write = 1'b0;
    chk("wr_addr", 32'(mem_addr), 32'd5);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_req", 32'(mem_req), 32'd1);
    cyc();
    chk("wr_we_hold", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_we_off", 32'(mem_we), 32'd0);
    chk("wr_mdr_kept", MDR_out, 32'hDEAD_BEEF);
    cyc();
    chk("wr_done_gone", 32'(done), 32'd0);
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    bc = int'(busy);
    dc = int'(done);
    mem_rdata = 32'hCAFE_BABE;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 2);
      cyc();
      bc += int'(busy);
      dc += int'(done);
    end
    mem_ack = 1'b0;
    chk("rd_busy_cycles", 32'(bc), 32'd3);
    chk("rd_done_pulses", 32'(dc), 32'd1);
    chk("rd_mdr", MDR_out, 32'hCAFE_BABE);
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    chk("lat_req", 32'(mem_req), 32'd1);
    chk("lat_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1122_3344;
    cyc();
    mem_ack = 1'b0;
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_mdr", MDR_out, 32'h1122_3344);
    cyc();
    mem_rdata = 32'hFFFF_0000;
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    bc = int'(busy);
    for (int i = 0; i < 15; i++) begin
      cyc();
      bc += int'(busy);
    end
    chk("to_busy_cycles", 32'(bc), 32'd16);
    cyc();
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_mdr", MDR_out, 32'h1122_3344);
    cyc();
    chk("to_req_low", 32'(mem_req), 32'd0);
    chk("to_err_low", 32'(err), 32'd0);
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    cyc();
    mem_ack = 1'b0;
    chk("race_done", 32'(done), 32'd1);
    chk("race_err", 32'(err), 32'd0);
    chk("race_mdr", MDR_out, 32'hA5A5_A5A5);
    cyc();
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    bus_in = 32'h1234_5678;
    e_MDR = 1'b1;
    mem_write = 1'b1;
    cyc();
    e_MDR = 1'b0;
    mem_write = 1'b0;
    bus_in = 32'h0000_01FF;
    e_MAR = 1'b1;
    cyc();
    e_MAR = 1'b0;
    chk("busy_mdr_kept", MDR_out, 32'hA5A5_A5A5);
    chk("busy_mar_kept", 32'(mem_addr), 32'd5);
    chk("busy_still_read", 32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    cyc();
    mem_ack = 1'b0;
    chk("busy_rd_mdr", MDR_out, 32'h0BAD_F00D);
    e_MAR = 1'b1;
    mem_write = 1'b1;
    cyc();
    e_MAR = 1'b0;
    mem_write = 1'b0;
    chk("done_mar_kept", 32'(mem_addr), 32'd5);
    chk("done_cmd_ignored", 32'(busy), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_7777;
    cyc();
    mem_ack = 1'b0;
    chk("idle_ack_mdr", MDR_out, 32'h0BAD_F00D);
    chk("idle_ack_done", 32'(done), 32'd0);
    mem_read = 1'b1;
    mem_write = 1'b1;
    cyc();
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk("both_req", 32'(mem_req), 32'd1);
    chk("both_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0055;
    cyc();
    mem_ack = 1'b0;
    cyc();
    bus_in = 32'h0000_003A;
    e_MAR = 1'b1;
    mem_read = 1'b1;
    cyc();
    e_MAR = 1'b0;
    mem_read = 1'b0;
    chk("same_cyc_addr", 32'(mem_addr), 32'h3A);
    chk("same_cyc_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk_idle_zero("abort");
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    cyc();
    mem_ack = 1'b0;
    chk("abort_ack_done", 32'(done), 32'd0);
    chk("abort_ack_mdr", MDR_out, 32'd0);
    chk("abort_ack_busy", 32'(busy), 32'd0);
    cyc();
    chk("abort_late_done", 32'(done), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
